ext_mul_execute: RTL
====================

EXT_MUL_EXECUTE -- requirements
Module: ext_mul_execute

Interface
REQ-001 SHALL have one clock, CLK; reset RST is synchronous and active-high.
REQ-002 Ports, one per line (name, direction, width, meaning):
- CLK  in  1  clock, rising-edge.
- RST  in  1  synchronous active-high reset.
- start  in  1  RISC-MGMT launch strobe for this extension.
- op  in  2  operation, held by the extension decode stage while start=1: 00 MUL, 01 MULH (signed x signed), 10 MULHU (unsigned x unsigned), 11 reserved.
- rdata_s_0  in  32  source operand A.
- rdata_s_1  in  32  source operand B.
- pc  in  32  PC of the instruction; unused except for exception context.
- exception  out  1  illegal-op indication.
- busy  out  1  stall request to RISC-MGMT.
- reg_w  out  1  register write strobe.
- reg_wdata  out  32  write data.
- branch_jump  out  1  branch request, constant 0.
- br_j_addr  out  32  branch target, constant 0.
REQ-003 Outputs SHALL drive the RISC-MGMT execute-interface extension side unmodified.

Function
REQ-004 SHALL implement FSM states IDLE, RUN, DONE.
REQ-005 IDLE, start=1, op!=11: latch |A|, |B|, result sign and op; clear 64-bit product and 6-bit counter; next state RUN.
REQ-006 Sign handling: MULH uses two's-complement magnitudes, result sign = sign(A) XOR sign(B); MUL and MULHU treat operands as unsigned.
REQ-007 RUN: each cycle, radix-2 shift-add (one multiplier bit, LSB first); counter increments; after 32 RUN cycles, next state DONE.
REQ-008 DONE: product negated if result sign=1; reg_wdata = product[31:0] for MUL, product[63:32] for MULH/MULHU; reg_w=1 for exactly this cycle; next state IDLE.
REQ-009 busy SHALL be combinational: 1 in IDLE when start=1 and op!=11; 1 throughout RUN; 0 in DONE and otherwise.
REQ-010 Latency: start sampled in cycle 0 -> RUN cycles 1..32 -> DONE/reg_w in cycle 33; next start accepted in cycle 34.
REQ-011 IDLE, start=1, op=11: exception=1 combinationally that cycle only; busy=0; reg_w never asserted; state stays IDLE.
REQ-012 start asserted in RUN or DONE SHALL be ignored; latched operands unaffected.
REQ-013 Operand changes after cycle 0 SHALL NOT affect the result.
REQ-014 reg_wdata SHALL be 0 whenever reg_w=0.
REQ-015 exception SHALL be 0 except per REQ-011; branch_jump and br_j_addr SHALL always be 0.

Reset
REQ-016 RST=1 at a clock edge SHALL force IDLE and clear product, counter and latched operands, regardless of state.
REQ-017 From the cycle after reset: busy=0, reg_w=0, reg_wdata=0, exception=0 (unless REQ-011 applies), branch_jump=0, br_j_addr=0.
REQ-018 Reset mid-RUN SHALL abandon the operation with no reg_w pulse; a start in the first post-reset cycle SHALL be accepted.

Verification
REQ-019 MUL, A=7, B=6, start one cycle -> busy=1 cycles 0-32, reg_w=1 and reg_wdata=0x0000002A in cycle 33 only.
REQ-020 MULHU, A=B=0xFFFFFFFF -> reg_wdata=0xFFFFFFFE; MULH same operands -> 0x00000000; MULH A=B=0x80000000 -> 0x40000000; MULH A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
REQ-021 op=11 with start=1 -> exception=1 that cycle, busy=0, no reg_w in the following 40 cycles.
REQ-022 MUL 3x5 started; start re-pulsed with A=9, B=9 in cycle 10 -> reg_wdata=0x0000000F in cycle 33; no second reg_w.
REQ-023 RST pulsed in cycle 10 of a MUL -> busy=0 from cycle 11; no reg_w; a new MUL 2x2 started in cycle 11 -> reg_wdata=4 in cycle 44.
REQ-024 Back-to-back MUL 2x3 then MUL 4x5, second start in cycle 34 -> reg_w pulses in cycles 33 and 67 with 6 and 20.

Source files
------------

// File: rtl/ext_mul_execute_if.sv
// Execute-interface bundle between RISC-MGMT (master) and the multiply extension (slave).
interface ext_mul_execute_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rdata_s_0;
    logic [31:0] rdata_s_1;
    logic [31:0] pc;
    logic        exception;
    logic        busy;
    logic        reg_w;
    logic [31:0] reg_wdata;
    logic        branch_jump;
    logic [31:0] br_j_addr;

    modport slave (
        input  start, op, rdata_s_0, rdata_s_1, pc,
        output exception, busy, reg_w, reg_wdata, branch_jump, br_j_addr
    );

    modport master (
        output start, op, rdata_s_0, rdata_s_1, pc,
        input  exception, busy, reg_w, reg_wdata, branch_jump, br_j_addr
    );
endinterface

// File: rtl/ext_mul_execute.sv
// Iterative 32x32 multiply extension: MUL / MULH / MULHU via 32-cycle radix-2 shift-add
// on operand magnitudes, with the sign applied to the 64-bit product at the end.
module ext_mul_execute (
    input  logic               CLK,
    input  logic               RST,
    ext_mul_execute_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULH  = 2'b01,
        OP_MULHU = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        neg_q, neg_d;
    logic [1:0]  op_q, op_d;
    logic [63:0] prod_q, prod_d;
    logic [5:0]  cnt_q, cnt_d;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] result;

    // Operand magnitudes and final signed product.
    always_comb begin
        a_mag  = bus.rdata_s_0;
        b_mag  = bus.rdata_s_1;
        if (op_t'(bus.op) == OP_MULH) begin
            if (bus.rdata_s_0[31]) a_mag = 32'd0 - bus.rdata_s_0;
            if (bus.rdata_s_1[31]) b_mag = 32'd0 - bus.rdata_s_1;
        end
        result = neg_q ? (64'd0 - prod_q) : prod_q;
    end

    // Next-state, datapath update and extension-side outputs.
    always_comb begin
        state_d         = state_q;
        a_d             = a_q;
        b_d             = b_q;
        neg_d           = neg_q;
        op_d            = op_q;
        prod_d          = prod_q;
        cnt_d           = cnt_q;
        bus.exception   = 1'b0;
        bus.busy        = 1'b0;
        bus.reg_w       = 1'b0;
        bus.reg_wdata   = '0;
        bus.branch_jump = 1'b0;
        bus.br_j_addr   = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (op_t'(bus.op) == OP_RSVD) begin
                        bus.exception = 1'b1;
                    end else begin
                        bus.busy = 1'b1;
                        a_d      = a_mag;
                        b_d      = b_mag;
                        neg_d    = (op_t'(bus.op) == OP_MULH) &&
                                   (bus.rdata_s_0[31] ^ bus.rdata_s_1[31]);
                        op_d     = bus.op;
                        prod_d   = '0;
                        cnt_d    = '0;
                        state_d  = RUN;
                    end
                end
            end

            RUN: begin
                bus.busy = 1'b1;
                if (b_q[cnt_q[4:0]]) begin
                    prod_d = prod_q + ({32'd0, a_q} << cnt_q);
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                bus.reg_w     = 1'b1;
                bus.reg_wdata = (op_t'(op_q) == OP_MUL) ? result[31:0] : result[63:32];
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
